// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and widths for the PLL reset sequencer
// Holds the sequencer state enum and the width constants used by the
// sequencer top and its optional lock-loss counter.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the PLL lock indication
// Ports:
//   clk      - destination clock
//   rst_n    - synchronous active-low reset, clears both flops
//   async_in - level signal from another clock domain
//   sync_out - async_in delayed by two clk cycles
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset / lock-qualification / downstream release sequencer
// Pulses the PLL reset, waits for a synchronized lock, qualifies it for a
// number of consecutive cycles, then releases the downstream reset. Lock
// timeouts are retried a limited number of times before a sticky failure.
// Optional feature: define PLL_SEQ_LOSS_CNT_EN to add lock_loss_cnt.
// Ports:
//   refclk        - reference clock, sole clock of the block
//   rst_n         - synchronous active-low reset
//   restart       - single-cycle request to re-run the whole sequence
//   pll_locked    - PLL lock, asynchronous to refclk
//   pll_rst       - active-high PLL reset (registered)
//   sys_rst_n     - active-low downstream reset, high only in RUN (registered)
//   fail          - high while in FAIL (registered)
//   state         - current sequencer state
//   retry_cnt     - lock attempts consumed
//   lock_loss_cnt - RUN lock-loss events, saturating (PLL_SEQ_LOSS_CNT_EN only)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYC     = 16,
    parameter int STABLE_CYC  = 1024,
    parameter int TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY   = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

    // One shared counter covers every timed phase, so it is sized for the
    // longest one; each phase stops it at its own terminal value.
    localparam int CNT_MAX_A = (RST_CYC > STABLE_CYC) ? RST_CYC : STABLE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    seq_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       retry_q;
    logic [1:0]       retry_inc;
    logic             locked_s;

    pll_lock_sync u_sync (
        .clk      (refclk),
        .rst_n    (rst_n),
        .async_in (pll_locked),
        .sync_out (locked_s)
    );

    // Saturating increment so retry_cnt can never pass MAX_RETRY.
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;

    // Outputs are registered together with the state so that they change in
    // the same cycle the state they belong to becomes visible.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fail      <= 1'b0;
        end else if (restart) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fail      <= 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_q <= retry_inc;
                        cnt_q   <= '0;
                        pll_rst <= 1'b1;
                        if (retry_inc == RETRY_MAX) begin
                            state_q <= ST_FAIL;
                            fail    <= 1'b1;
                        end else begin
                            state_q <= ST_PLL_RST;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    // A single unlocked cycle restarts qualification with a
                    // fresh timeout but does not count as a failed attempt.
                    if (!locked_s) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= '0;
                        sys_rst_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    // Losing lock after release is a fresh start, not a retry.
                    if (!locked_s) begin
                        state_q   <= ST_PLL_RST;
                        cnt_q     <= '0;
                        retry_q   <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst_n <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    fail      <= 1'b1;
                end
                default: begin
                    state_q   <= ST_PLL_RST;
                    cnt_q     <= '0;
                    retry_q   <= '0;
                    pll_rst   <= 1'b1;
                    sys_rst_n <= 1'b0;
                    fail      <= 1'b0;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [LOSS_W-1:0] loss_q;

    // Counts only genuine RUN lock losses; a simultaneous restart wins and
    // the event is not recorded. Survives restart, cleared only by rst_n.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (!restart && state_q == ST_RUN && !locked_s && loss_q != '1) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer against a timestamp model
module tb_pll_reset_sequencer;

    localparam int RST_CYC     = 4;
    localparam int STABLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 32;
    localparam int MAX_RETRY   = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYC     (RST_CYC),
        .STABLE_CYC  (STABLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .restart       (restart),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .fail          (fail),
        .state         (state),
        .retry_cnt     (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: phase number plus the cycle it was entered; phase
    // length is elapsed time, and locked_s is pll_locked seen through a
    // two-entry delay queue.
    int m_ph    = 0;
    int m_enter = 0;
    int m_retry = 0;
    int m_loss  = 0;
    int cyc     = 0;
    bit lq[$];

    task automatic enter(input int p);
        m_ph    = p;
        m_enter = cyc + 1;
    endtask

    task automatic model_edge();
        bit ls;
        int n;
        ls = lq[0];
        n  = cyc - m_enter + 1;
        if (!rst_n) begin
            enter(0);
            m_retry = 0;
            m_loss  = 0;
            lq      = {1'b0, 1'b0};
        end else begin
            if (restart) begin
                enter(0);
                m_retry = 0;
            end else begin
                case (m_ph)
                    0: if (n == RST_CYC) enter(1);
                    1: begin
                        if (ls) enter(2);
                        else if (n == TIMEOUT_CYC) begin
                            if (m_retry < MAX_RETRY) m_retry++;
                            enter((m_retry == MAX_RETRY) ? 4 : 0);
                        end
                    end
                    2: begin
                        if (!ls) enter(1);
                        else if (n == STABLE_CYC) enter(3);
                    end
                    3: if (!ls) begin
                        enter(0);
                        m_retry = 0;
                        if (m_loss < 255) m_loss++;
                    end
                    default: ;
                endcase
            end
            lq.push_back(pll_locked);
            void'(lq.pop_front());
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
        chk("state", state, m_ph);
        chk("pll_rst", pll_rst, (m_ph == 0 || m_ph == 4));
        chk("sys_rst_n", sys_rst_n, (m_ph == 3));
        chk("fail", fail, (m_ph == 4));
        chk("retry_cnt", retry_cnt, m_retry);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    endtask

    task automatic wait_ph(input int p, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_ph == p) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        if (m_ph == p) hit = 1'b1;
        chk({tag, "_bound"}, hit, 1);
        chk(tag, state, p);
    endtask

    task automatic pulse_width(input string tag, input int exp);
        int w;
        w = 0;
        while (pll_rst === 1'b1 && w < 20) begin
            w++;
            tick();
        end
        chk(tag, w, exp);
    endtask

    int hold;
    bit seen;

    initial begin
        lq         = {1'b0, 1'b0};
        rst_n      = 1'b0;
        restart    = 1'b0;
        pll_locked = 1'b0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry_cnt, 0);

        // Nominal bring-up: release at cycle 0, lock at cycle 10.
        rst_n = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            if (c == 3)  chk("nom_pll_rst_c3", pll_rst, 1);
            if (c == 4)  chk("nom_pll_rst_c4", pll_rst, 0);
            if (c == 11) chk("nom_locked_s_c11", dut.locked_s, 0);
            if (c == 12) chk("nom_locked_s_c12", dut.locked_s, 1);
            if (c == 20) chk("nom_sys_rst_n_c20", sys_rst_n, 0);
            if (c == 21) begin
                chk("nom_sys_rst_n_c21", sys_rst_n, 1);
                chk("nom_state_c21", state, 3);
            end
            if (c == 10) pll_locked = 1'b1;
            tick();
        end

        // Lock loss in RUN.
        pll_locked = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sys_rst_n === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("loss_sys_rst_n_within3", seen, 1);
        chk("loss_state", state, 0);
        pulse_width("loss_pulse", RST_CYC);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("loss_cnt_first", lock_loss_cnt, 1);
`endif

        // Lock never returns: two timeouts then FAIL, then restart.
        wait_ph(4, 150, "to_fail");
        chk("to_fail_fail", fail, 1);
        chk("to_fail_retry", retry_cnt, 2);
        chk("to_fail_pll_rst", pll_rst, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("fail_sticky", fail, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_state", state, 0);
        chk("restart_fail", fail, 0);
        chk("restart_retry", retry_cnt, 0);

        // One timeout, then lock, then a glitch during STABLE.
        wait_ph(1, 10, "gl_wait1");
        wait_ph(0, 40, "gl_timeout");
        chk("gl_retry_after_timeout", retry_cnt, 1);
        pll_locked = 1'b1;
        wait_ph(2, 50, "gl_stable");
        tick();
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_ph(1, 5, "gl_back_wait");
        chk("gl_retry_kept", retry_cnt, 1);
        chk("gl_sys_rst_n_low", sys_rst_n, 0);
        wait_ph(3, 60, "gl_run");
        chk("gl_run_sys_rst_n", sys_rst_n, 1);

        // Restart coinciding with lock loss in RUN.
        pll_locked = 1'b0;
        tick();
        tick();
        chk("rl_locked_s_low", dut.locked_s, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rl_state", state, 0);
        chk("rl_retry", retry_cnt, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("rl_loss_cnt_unchanged", lock_loss_cnt, 1);
`endif

        // Reset asserted in STABLE, then full pulse after release.
        pll_locked = 1'b1;
        wait_ph(2, 60, "rs_stable");
        tick();
        rst_n = 1'b0;
        tick();
        chk("rs_state", state, 0);
        chk("rs_pll_rst", pll_rst, 1);
        chk("rs_sys_rst_n", sys_rst_n, 0);
        rst_n = 1'b1;
        pulse_width("rs_pulse", RST_CYC);

        // Randomized traffic against the model.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 80);
            end else begin
                hold--;
            end
            restart = ($urandom_range(0, 199) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            tick();
        end
        restart = 1'b0;
        rst_n   = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- RST_CYC, 16, pll_rst pulse width in cycles.
- STABLE_CYC, 1024, consecutive synced-lock cycles required before release.
- TIMEOUT_CYC, 65536, max WAIT_LOCK cycles per attempt.
- MAX_RETRY, 3, lock attempts before FAIL.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- refclk, input, 1, free-running reference clock.
- rst_n, input, 1, synchronous active-low reset.
- restart, input, 1, single-cycle request to re-run the sequence.
- pll_locked, input, 1, PLL lock indication, asynchronous to refclk.
- pll_rst, output, 1, active-high PLL reset.
- sys_rst_n, output, 1, active-low downstream reset.
- fail, output, 1, sticky lock-failure flag.
- state, output, 3, current FSM state.
- retry_cnt, output, 2, lock attempts consumed.
REQ-003 The block SHALL use one clock (refclk); reset SHALL be synchronous and active-low (rst_n).

Function
REQ-004 pll_locked SHALL pass through a 2-flop synchronizer; locked_s SHALL equal pll_locked delayed 2 cycles.
REQ-005 State encoding SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
REQ-006 PLL_RST SHALL hold pll_rst=1 for exactly RST_CYC cycles, then go to WAIT_LOCK with pll_rst=0 and the cycle counter cleared.
REQ-007 In WAIT_LOCK, locked_s=1 SHALL move to STABLE with the counter cleared.
REQ-008 In WAIT_LOCK, the counter reaching TIMEOUT_CYC-1 without lock SHALL increment retry_cnt, then go to FAIL if the new value equals MAX_RETRY, else to PLL_RST.
REQ-009 STABLE SHALL require locked_s=1 for STABLE_CYC consecutive cycles, then go to RUN.
REQ-010 Any locked_s=0 cycle in STABLE SHALL return to WAIT_LOCK with a fresh timeout count and SHALL NOT change retry_cnt.
REQ-011 sys_rst_n SHALL be registered and SHALL be 1 only while state=RUN; it SHALL rise in the same cycle state becomes RUN.
REQ-012 In RUN, locked_s=0 SHALL go to PLL_RST and clear retry_cnt; sys_rst_n SHALL be 0 on the following cycle.
REQ-013 FAIL SHALL hold pll_rst=1, sys_rst_n=0 and fail=1 until restart or reset.
REQ-014 restart=1 in any state SHALL force PLL_RST, clear retry_cnt, fail and the counter, and SHALL take priority over all other transitions in that cycle.
REQ-015 Counters SHALL be sized $clog2 of the largest count parameter and SHALL never wrap; retry_cnt SHALL saturate at MAX_RETRY.

Reset
REQ-016 While rst_n=0: state=PLL_RST, pll_rst=1, sys_rst_n=0, fail=0, retry_cnt=0, counter=0, synchronizer flops=0.
REQ-017 Reset asserted mid-sequence (any state) SHALL restart from PLL_RST with a full RST_CYC pulse after rst_n returns to 1.

Configuration
REQ-018 With PLL_SEQ_LOSS_CNT_EN defined, an extra output lock_loss_cnt[7:0] SHALL count RUN-to-PLL_RST lock-loss events, saturate at 255, and clear only on rst_n.
REQ-019 Without PLL_SEQ_LOSS_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 Package pll_seq_pkg SHALL hold the state enum, the state width constant (3), and the lock_loss_cnt width constant (8).
REQ-021 The synchronizer SHALL be sub-module pll_lock_sync (2 flops, reset to 0); all other logic SHALL stay in pll_reset_sequencer.

Verification (RST_CYC=4, STABLE_CYC=8, TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-022 rst_n released at cycle 0, pll_locked rises at cycle 10 -> pll_rst=1 cycles 0-3, locked_s=1 at cycle 12, sys_rst_n=1 at cycle 21, state=3.
REQ-023 pll_locked held 0 -> two timeouts -> state=4, fail=1, retry_cnt=2, pll_rst=1; restart pulse -> state=0, fail=0, retry_cnt=0.
REQ-024 pll_locked 1-cycle low glitch during STABLE -> returns to WAIT_LOCK, retry_cnt unchanged, sys_rst_n stays 0, later release proceeds.
REQ-025 pll_locked drops in RUN -> sys_rst_n=0 within 3 cycles, state=0, pll_rst pulses 4 cycles; with PLL_SEQ_LOSS_CNT_EN defined, lock_loss_cnt increments by 1.
REQ-026 rst_n asserted during STABLE -> next cycle state=0, pll_rst=1, sys_rst_n=0; restart and lock loss in the same cycle -> restart behaviour only.
